core_mem_arbiter: RTL



---
 rtl/core_mem_arb_pkg.sv | 19 +
 rtl/core_arb_rr2.sv | 24 ++
 rtl/core_mem_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/core_mem_arb_pkg.sv
// Shared types and constants for the core memory arbiter: FSM states, channel
// owner encoding, and the fixed attributes of an instruction fetch.
package core_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    localparam logic [2:0] COP_RD     = 3'b000;
    localparam logic [2:0] FETCH_SIZE = 3'd4;

endpackage

// File: rtl/core_arb_rr2.sv
// Two-way round-robin pick between the fetch and data channels. Purely
// combinational; the caller owns the last-grant register.
module core_arb_rr2
    import core_mem_arb_pkg::*;
(
    input  logic   i_fetch_val,
    input  logic   i_data_val,
    input  owner_e i_last_grant,
    output logic   o_grant,
    output owner_e o_owner
);

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        o_grant = i_fetch_val | i_data_val;
        o_owner = OWN_I;
        if (i_fetch_val && i_data_val) begin
            o_owner = (i_last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (i_data_val) begin
            o_owner = OWN_D;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory request port between the core's fetch and data channels:
// one outstanding transaction, round-robin on contention, sticky watchdog.
module core_mem_arbiter
    import core_mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_val,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ack,
    output logic [DATA_W-1:0] i_ack_rdata,
    input  logic              d_req_val,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [2:0]        d_req_cop,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [2:0]        d_req_size,
    output logic              d_req_ack,
    output logic [DATA_W-1:0] d_ack_rdata,
    output logic              m_req_val,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [2:0]        m_req_cop,
    output logic [DATA_W-1:0] m_req_wdata,
    output logic [2:0]        m_req_size,
    input  logic              m_req_ack,
    input  logic [DATA_W-1:0] m_ack_rdata,
    output logic              timeout_err
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SET = CNT_W'(TIMEOUT_CYCLES - 2);

    state_e            r_state;
    state_e            w_state_next;
    owner_e            r_owner;
    owner_e            r_last_grant;
    owner_e            w_grant_owner;
    logic              w_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_cop;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_size;
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_timeout_err;

    core_arb_rr2 u_rr (
        .i_fetch_val  (i_req_val),
        .i_data_val   (d_req_val),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_owner      (w_grant_owner)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_next = BUSY;
            BUSY:    if (m_req_ack) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= OWN_I;
            r_last_grant  <= OWN_D;
            r_addr        <= '0;
            r_cop         <= '0;
            r_wdata       <= '0;
            r_size        <= '0;
            r_rdata       <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_grant_owner;
                        r_last_grant <= w_grant_owner;
                        r_cnt        <= '0;
                        if (w_grant_owner == OWN_I) begin
                            r_addr  <= i_req_addr;
                            r_cop   <= COP_RD;
                            r_wdata <= '0;
                            r_size  <= FETCH_SIZE;
                        end else begin
                            r_addr  <= d_req_addr;
                            r_cop   <= d_req_cop;
                            r_wdata <= d_req_wdata;
                            r_size  <= d_req_size;
                        end
                    end
                end
                BUSY: begin
                    if (m_req_ack) begin
                        r_rdata <= m_ack_rdata;
                    end else begin
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
                        // Flag is registered one silent cycle early so it is
                        // visible in the TIMEOUT_CYCLES-th BUSY cycle.
                        if (r_cnt == CNT_SET) r_timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_req_val   = (r_state == BUSY);
    assign m_req_addr  = r_addr;
    assign m_req_cop   = r_cop;
    assign m_req_wdata = r_wdata;
    assign m_req_size  = r_size;

    assign i_req_ack   = (r_state == RESP) && (r_owner == OWN_I);
    assign d_req_ack   = (r_state == RESP) && (r_owner == OWN_D);
    assign i_ack_rdata = i_req_ack ? r_rdata : '0;
    assign d_ack_rdata = d_req_ack ? r_rdata : '0;
    assign timeout_err = r_timeout_err;

endmodule
